// File: rtl/mf_gate_identifier_pkg.sv
// Shared encodings for the multi-function gate characteriser: decoded modes,
// expected response signatures and the FSM state encoding.
package mf_gate_pkg;

    typedef enum logic [1:0] {
        MODE_PASS_X  = 2'd0,
        MODE_INV_X   = 2'd1,
        MODE_PASS_Y  = 2'd2,
        MODE_UNKNOWN = 2'd3
    } mode_e;

    // Bit i of a signature is f observed with {x,y} = i
    localparam logic [3:0] SIG_PASS_X = 4'b1100;
    localparam logic [3:0] SIG_INV_X  = 4'b0011;
    localparam logic [3:0] SIG_PASS_Y = 4'b1010;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DECIDE = 3'd4
    } state_e;

endpackage

// File: rtl/mf_gate_identifier_if.sv
// Request/result handshake plus the stimulus/response wires to the gate under test.
interface mf_gate_identifier_if;
    import mf_gate_pkg::*;

    logic       start;
    logic       f_in;
    logic       x_drv;
    logic       y_drv;
    logic       busy;
    logic       done;
    mode_e      mode;
    logic       fault;
    logic [3:0] signature;

    modport master (
        output start, f_in,
        input  x_drv, y_drv, busy, done, mode, fault, signature
    );

    modport slave (
        input  start, f_in,
        output x_drv, y_drv, busy, done, mode, fault, signature
    );

endinterface

// File: rtl/mf_gate_identifier_settle_timer.sv
// Loadable down-counter with a zero flag; used to pace the settle wait per vector.
module mf_settle_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mf_gate_identifier.sv
// Drives all four (x,y) vectors onto a gate with hidden a,b, samples f after a
// settle time and decodes which function the gate performs.
module mf_gate_identifier
    import mf_gate_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mf_gate_identifier_if.slave  bus
);

    state_e     state;
    logic [1:0] vec_idx;
    logic       tmr_load;
    logic       tmr_dec;
    logic       tmr_zero;

    function automatic mode_e decode_mode(input logic [3:0] sig);
        case (sig)
            SIG_PASS_X: decode_mode = MODE_PASS_X;
            SIG_INV_X:  decode_mode = MODE_INV_X;
            SIG_PASS_Y: decode_mode = MODE_PASS_Y;
            default:    decode_mode = MODE_UNKNOWN;
        endcase
    endfunction

    assign tmr_load = (state == ST_APPLY);
    assign tmr_dec  = (state == ST_SETTLE);

    mf_settle_timer #(
        .CNT_W (CNT_W)
    ) u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .dec      (tmr_dec),
        .load_val (CNT_W'(SETTLE_CYCLES - 1)),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            vec_idx       <= 2'd0;
            bus.x_drv     <= 1'b0;
            bus.y_drv     <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.fault     <= 1'b0;
            bus.mode      <= MODE_UNKNOWN;
            bus.signature <= 4'd0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state         <= ST_APPLY;
                        bus.busy      <= 1'b1;
                        vec_idx       <= 2'd0;
                        bus.signature <= 4'd0;
                        bus.fault     <= 1'b0;
                    end
                end
                ST_APPLY: begin
                    {bus.x_drv, bus.y_drv} <= vec_idx;
                    state                  <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (tmr_zero) state <= ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    bus.signature[vec_idx] <= bus.f_in;
                    if (vec_idx == 2'd3) begin
                        state <= ST_DECIDE;
                    end else begin
                        vec_idx <= vec_idx + 2'd1;
                        state   <= ST_APPLY;
                    end
                end
                ST_DECIDE: begin
                    // busy drops on the same edge that raises done, so they never overlap
                    bus.mode  <= decode_mode(bus.signature);
                    bus.fault <= (decode_mode(bus.signature) == MODE_UNKNOWN);
                    bus.done  <= 1'b1;
                    bus.busy  <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mf_gate_identifier.sv
// Bench for mf_gate_identifier: gate model, timing-based behavioural model with a
// per-cycle compare, and directed runs with literal expectations.
module tb_mf_gate_identifier;

    localparam int PER0 = 4 + 2;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   nchk = 0;
    int   nerr = 0;
    bit   chk_en = 1'b0;
    int   gate_sel;

    mf_gate_identifier_if bus0 ();
    mf_gate_identifier_if bus1 ();

    mf_gate_identifier #(.SETTLE_CYCLES(4), .CNT_W(8)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    mf_gate_identifier #(.SETTLE_CYCLES(1), .CNT_W(8)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Gate under test: sel 0..3 is ab, sel 4 is a stuck-at-1 output
    function automatic logic gate_f(input int sel, input logic x, input logic y);
        case (sel)
            0:       gate_f = x;
            3:       gate_f = ~x;
            1, 2:    gate_f = y;
            default: gate_f = 1'b1;
        endcase
    endfunction

    always_comb bus0.f_in = gate_f(gate_sel, bus0.x_drv, bus0.y_drv);
    always_comb bus1.f_in = bus1.x_drv;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural model: edge n after acceptance; vector v applied at n=1+PER*v,
    // sampled at n=PER*(v+1), result published at n=4*PER+1.
    bit         m_act;
    int         m_n;
    bit         e_busy, e_done, e_fault, e_x, e_y;
    logic [1:0] e_mode;
    logic [3:0] e_sig;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act = 0; m_n = 0;
            e_busy = 0; e_done = 0; e_fault = 0; e_x = 0; e_y = 0;
            e_mode = 2'd3; e_sig = 4'd0;
        end else begin
            e_done = 0;
            if (!m_act) begin
                if (bus0.start) begin
                    m_act = 1; m_n = 0; e_busy = 1; e_sig = 4'd0; e_fault = 0;
                end
            end else begin
                m_n++;
                if (m_n >= 1 && m_n <= 3 * PER0 + 1 && (m_n - 1) % PER0 == 0) begin
                    e_x = (((m_n - 1) / PER0) & 2) != 0;
                    e_y = (((m_n - 1) / PER0) & 1) != 0;
                end
                if (m_n >= PER0 && m_n <= 4 * PER0 && m_n % PER0 == 0) begin
                    int v;
                    v = m_n / PER0 - 1;
                    e_sig[v] = gate_f(gate_sel, (v & 2) != 0, (v & 1) != 0);
                end
                if (m_n == 4 * PER0 + 1) begin
                    e_done = 1; e_busy = 0; m_act = 0;
                    if (e_sig == 4'b1100)      e_mode = 2'd0;
                    else if (e_sig == 4'b0011) e_mode = 2'd1;
                    else if (e_sig == 4'b1010) e_mode = 2'd2;
                    else                       e_mode = 2'd3;
                    e_fault = (e_mode == 2'd3);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_busy", 32'(bus0.busy), 32'(e_busy));
            chk("m_done", 32'(bus0.done), 32'(e_done));
            chk("m_xy", 32'({bus0.x_drv, bus0.y_drv}), 32'({e_x, e_y}));
            chk("m_sig", 32'(bus0.signature), 32'(e_sig));
            chk("m_mode", 32'(bus0.mode), 32'(e_mode));
            chk("m_fault", 32'(bus0.fault), 32'(e_fault));
            chk("m_done_busy_excl", 32'(bus0.done & bus0.busy), 32'd0);
        end
    end

    task automatic run0(input int sel, input logic [3:0] exp_sig, input int exp_mode,
                        input bit exp_fault, input bit poke);
        int t0, rel, lat, bcnt, dcnt;
        lat = 0; bcnt = 0; dcnt = 0;
        gate_sel = sel;
        @(negedge clk);
        bus0.start = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            rel = cyc - t0;
            bus0.start = poke && (rel == 5 || rel == 12);
            if (bus0.busy) bcnt++;
            if (bus0.done) begin
                dcnt++;
                if (lat == 0) lat = rel;
            end
        end
        chk("latency", 32'(lat), 32'd26);
        chk("busy_cycles", 32'(bcnt), 32'd25);
        chk("done_pulses", 32'(dcnt), 32'd1);
        chk("signature", 32'(bus0.signature), 32'(exp_sig));
        chk("mode", 32'(bus0.mode), 32'(exp_mode));
        chk("fault", 32'(bus0.fault), 32'(exp_fault));
        chk("xy_hold", 32'({bus0.x_drv, bus0.y_drv}), 32'd3);
    endtask

    initial begin
        int t0, rel, dcnt, lat1;
        rst_n = 1'b0;
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        gate_sel = 0;
        repeat (3) @(negedge clk);
        chk("rst_mode", 32'(bus0.mode), 32'd3);
        chk("rst_busy", 32'(bus0.busy), 32'd0);
        chk("rst_done", 32'(bus0.done), 32'd0);
        chk("rst_fault", 32'(bus0.fault), 32'd0);
        chk("rst_sig", 32'(bus0.signature), 32'd0);
        chk("rst_xy", 32'({bus0.x_drv, bus0.y_drv}), 32'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        run0(0, 4'b1100, 0, 1'b0, 1'b0);
        run0(3, 4'b0011, 1, 1'b0, 1'b0);
        run0(1, 4'b1010, 2, 1'b0, 1'b0);
        run0(2, 4'b1010, 2, 1'b0, 1'b0);
        run0(4, 4'b1111, 3, 1'b1, 1'b0);
        run0(0, 4'b1100, 0, 1'b0, 1'b0);
        run0(1, 4'b1010, 2, 1'b0, 1'b1);

        // Reset while vector 2 is settling
        gate_sel = 3;
        @(negedge clk);
        bus0.start = 1'b1;
        t0 = cyc;
        do begin
            @(negedge clk);
            bus0.start = 1'b0;
            rel = cyc - t0;
        end while (rel < 16 && rel < 100);
        chk("pre_rst_xy", 32'({bus0.x_drv, bus0.y_drv}), 32'd2);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(bus0.busy), 32'd0);
        chk("mid_rst_done", 32'(bus0.done), 32'd0);
        chk("mid_rst_xy", 32'({bus0.x_drv, bus0.y_drv}), 32'd0);
        chk("mid_rst_mode", 32'(bus0.mode), 32'd3);
        chk("mid_rst_sig", 32'(bus0.signature), 32'd0);
        chk("mid_rst_fault", 32'(bus0.fault), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus0.done) dcnt++;
        end
        chk("rst_no_done", 32'(dcnt), 32'd0);
        run0(0, 4'b1100, 0, 1'b0, 1'b0);

        // One-cycle settle instance, gate fixed at ab=00
        lat1 = 0;
        @(negedge clk);
        bus1.start = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus1.start = 1'b0;
            rel = cyc - t0;
            if (rel >= 2 && rel <= 13) chk("s1_xy", 32'({bus1.x_drv, bus1.y_drv}), 32'((rel - 2) / 3));
            if (bus1.done && lat1 == 0) lat1 = rel;
        end
        chk("s1_latency", 32'(lat1), 32'd14);
        chk("s1_mode", 32'(bus1.mode), 32'd0);
        chk("s1_sig", 32'(bus1.signature), 32'b1100);
        chk("s1_fault", 32'(bus1.fault), 32'd0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
